// File: rtl/wb_writeback_unit_if.sv
// Bundle between the memory stage, data memory, register-file write port and the writeback unit.
// The unit takes the slave modport; the surrounding pipeline takes the master modport.
interface wb_writeback_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic            in_reg_wr;
    logic [4:0]      in_rd;
    logic [1:0]      in_wb_sel;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_alu_result;
    logic [XLEN-1:0] in_pc4;
    logic [XLEN-1:0] in_imm;
    logic            dmem_rvalid;
    logic [XLEN-1:0] dmem_rdata;
    logic            reg_wr;
    logic [4:0]      waddr;
    logic [XLEN-1:0] wdata;
    logic            stall;
    logic            load_err;

    modport master (
        output in_valid, in_reg_wr, in_rd, in_wb_sel, in_funct3,
               in_alu_result, in_pc4, in_imm, dmem_rvalid, dmem_rdata,
        input  in_ready, reg_wr, waddr, wdata, stall, load_err
    );

    modport slave (
        input  in_valid, in_reg_wr, in_rd, in_wb_sel, in_funct3,
               in_alu_result, in_pc4, in_imm, dmem_rvalid, dmem_rdata,
        output in_ready, reg_wr, waddr, wdata, stall, load_err
    );
endinterface

// File: rtl/wb_writeback_unit.sv
// Writeback stage: drives the register-file write port from retiring instructions,
// waiting in WAIT_LOAD for a data-memory response and flagging loads that time out.
module wb_writeback_unit #(
    parameter int XLEN         = 32,
    parameter int LOAD_TIMEOUT = 16
) (
    input logic                clock,
    input logic                reset,
    wb_writeback_unit_if.slave bus
);
    localparam int CNT_W = $clog2(LOAD_TIMEOUT + 1);

    typedef enum logic {
        IDLE,
        WAIT_LOAD
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [4:0]       rd_q, rd_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [1:0]       off_q, off_d;
    logic             ld_wr_q, ld_wr_d;
    logic             reg_wr_q, reg_wr_d;
    logic [4:0]       waddr_q, waddr_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic             load_err_q, load_err_d;

    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [XLEN-1:0]  load_data;

    // Load formatting works on the latched offset/type against the live response word.
    always_comb begin
        byte_sel = 8'(bus.dmem_rdata >> {off_q, 3'b000});
        half_sel = 16'(bus.dmem_rdata >> {off_q[1], 4'b0000});
        case (funct3_q)
            3'b000:  load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, byte_sel};
            3'b001:  load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, half_sel};
            default: load_data = bus.dmem_rdata;
        endcase
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d    = state_q;
        count_d    = count_q;
        rd_d       = rd_q;
        funct3_d   = funct3_q;
        off_d      = off_q;
        ld_wr_d    = ld_wr_q;
        reg_wr_d   = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        load_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.in_wb_sel == 2'b01) begin
                        state_d  = WAIT_LOAD;
                        count_d  = '0;
                        rd_d     = bus.in_rd;
                        funct3_d = bus.in_funct3;
                        off_d    = bus.in_alu_result[1:0];
                        ld_wr_d  = bus.in_reg_wr && (bus.in_rd != 5'd0);
                    end else if (bus.in_reg_wr && (bus.in_rd != 5'd0)) begin
                        reg_wr_d = 1'b1;
                        waddr_d  = bus.in_rd;
                        case (bus.in_wb_sel)
                            2'b10:   wdata_d = bus.in_pc4;
                            2'b11:   wdata_d = bus.in_imm;
                            default: wdata_d = bus.in_alu_result;
                        endcase
                    end
                end
            end
            WAIT_LOAD: begin
                // A response in the final allowed cycle still counts as on time.
                if (bus.dmem_rvalid) begin
                    state_d = IDLE;
                    if (ld_wr_q) begin
                        reg_wr_d = 1'b1;
                        waddr_d  = rd_q;
                        wdata_d  = load_data;
                    end
                end else if (count_q == CNT_W'(LOAD_TIMEOUT - 1)) begin
                    state_d    = IDLE;
                    load_err_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            rd_q       <= '0;
            funct3_q   <= '0;
            off_q      <= '0;
            ld_wr_q    <= 1'b0;
            reg_wr_q   <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_q       <= rd_d;
            funct3_q   <= funct3_d;
            off_q      <= off_d;
            ld_wr_q    <= ld_wr_d;
            reg_wr_q   <= reg_wr_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.in_ready = (state_q == IDLE) && !reset;
    assign bus.stall    = (state_q == WAIT_LOAD) && !reset;
    assign bus.reg_wr   = reg_wr_q;
    assign bus.waddr    = waddr_q;
    assign bus.wdata    = wdata_q;
    assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_wb_writeback_unit.sv
// Self-checking bench for wb_writeback_unit: directed cases with literal expectations,
// then randomized traffic compared every cycle against a cycle-deadline behavioural model.
module tb_wb_writeback_unit;
    localparam int XLEN = 32;
    localparam int TO   = 16;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    wb_writeback_unit_if #(.XLEN(XLEN)) bus ();

    wb_writeback_unit #(.XLEN(XLEN), .LOAD_TIMEOUT(TO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    // Model state: what the outputs must be in the current cycle.
    logic        m_busy  = 1'b0;
    logic        m_wr    = 1'b0;
    logic        m_err   = 1'b0;
    logic [4:0]  m_waddr = '0;
    logic [31:0] m_wdata = '0;
    // Pending load as a record plus its accept cycle (deadline = accept + TO).
    logic [4:0]  p_rd;
    logic        p_wr;
    logic [2:0]  p_f3;
    logic [1:0]  p_off;
    int          p_start;
    int          cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [1:0] off,
                                        input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * off[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    // Predict the outcome of the current inputs, take the edge, then publish the prediction.
    task automatic cycle();
        logic        n_busy, n_wr, n_err;
        logic [4:0]  n_addr;
        logic [31:0] n_data;
        n_busy = m_busy;
        n_wr   = 1'b0;
        n_err  = 1'b0;
        n_addr = m_waddr;
        n_data = m_wdata;
        if (reset) begin
            n_busy = 1'b0;
            n_addr = '0;
            n_data = '0;
        end else if (!m_busy) begin
            if (bus.in_valid) begin
                if (bus.in_wb_sel == 2'b01) begin
                    n_busy  = 1'b1;
                    p_rd    = bus.in_rd;
                    p_wr    = bus.in_reg_wr;
                    p_f3    = bus.in_funct3;
                    p_off   = bus.in_alu_result[1:0];
                    p_start = cyc;
                end else if (bus.in_reg_wr && bus.in_rd != 0) begin
                    n_wr   = 1'b1;
                    n_addr = bus.in_rd;
                    n_data = (bus.in_wb_sel == 2'b10) ? bus.in_pc4 :
                             (bus.in_wb_sel == 2'b11) ? bus.in_imm : bus.in_alu_result;
                end
            end
        end else if (bus.dmem_rvalid) begin
            n_busy = 1'b0;
            if (p_wr && p_rd != 0) begin
                n_wr   = 1'b1;
                n_addr = p_rd;
                n_data = fmt(p_f3, p_off, bus.dmem_rdata);
            end
        end else if (cyc - p_start >= TO) begin
            n_busy = 1'b0;
            n_err  = 1'b1;
        end
        @(posedge clock);
        #1;
        cyc++;
        m_busy  = n_busy;
        m_wr    = n_wr;
        m_err   = n_err;
        m_waddr = n_addr;
        m_wdata = n_data;
    endtask

    always @(negedge clock) begin
        if (cmp_en) begin
            check("reg_wr",   32'(bus.reg_wr),   32'(m_wr));
            check("waddr",    32'(bus.waddr),    32'(m_waddr));
            check("wdata",    bus.wdata,         m_wdata);
            check("load_err", 32'(bus.load_err), 32'(m_err));
            check("in_ready", 32'(bus.in_ready), 32'(!m_busy && !reset));
            check("stall",    32'(bus.stall),    32'(m_busy && !reset));
        end
    end

    task automatic quiet();
        bus.in_valid    = 1'b0;
        bus.in_reg_wr   = 1'b0;
        bus.in_rd       = '0;
        bus.in_wb_sel   = '0;
        bus.in_funct3   = '0;
        bus.in_alu_result = '0;
        bus.in_pc4      = 32'h1000_0004;
        bus.in_imm      = 32'hABCD_E000;
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata  = '0;
    endtask

    task automatic issue(input logic [1:0] sel, input logic [2:0] f3, input logic [4:0] rd,
                         input logic wr, input logic [31:0] alu);
        bus.in_valid      = 1'b1;
        bus.in_wb_sel     = sel;
        bus.in_funct3     = f3;
        bus.in_rd         = rd;
        bus.in_reg_wr     = wr;
        bus.in_alu_result = alu;
    endtask

    logic [2:0]  ld_f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  ld_off [5] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd0};
    logic [31:0] ld_exp [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h80FF1234};

    initial begin
        quiet();
        reset = 1'b1;
        cmp_en = 1'b1;
        cycle();
        cycle();
        check("rst_reg_wr", 32'(bus.reg_wr), 32'd0);
        check("rst_wdata",  bus.wdata,       32'd0);
        check("rst_ready",  32'(bus.in_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", 32'(bus.in_ready), 32'd1);

        // ALU writeback, one-cycle pulse
        issue(2'b00, 3'b000, 5'd5, 1'b1, 32'hDEADBEEF);
        cycle();
        bus.in_valid = 1'b0;
        check("alu_wr",    32'(bus.reg_wr), 32'd1);
        check("alu_waddr", 32'(bus.waddr),  32'd5);
        check("alu_wdata", bus.wdata,       32'hDEADBEEF);
        cycle();
        check("alu_wr_drop", 32'(bus.reg_wr), 32'd0);

        // Load formatting table
        for (int i = 0; i < 5; i++) begin
            issue(2'b01, ld_f3[i], 5'd9, 1'b1, 32'h2000_0000 | 32'(ld_off[i]));
            cycle();
            bus.in_valid    = 1'b0;
            bus.dmem_rvalid = 1'b1;
            bus.dmem_rdata  = 32'h80FF1234;
            cycle();
            bus.dmem_rvalid = 1'b0;
            check("load_wr",   32'(bus.reg_wr), 32'd1);
            check("load_data", bus.wdata,       ld_exp[i]);
        end

        // Response 3 cycles after accept, ALU instruction queued behind it
        issue(2'b01, 3'b010, 5'd4, 1'b1, 32'h0000_0100);
        cycle();
        issue(2'b00, 3'b000, 5'd6, 1'b1, 32'h0000_1111);
        for (int i = 0; i < 3; i++) begin
            check("wait_stall", 32'(bus.stall),    32'd1);
            check("wait_ready", 32'(bus.in_ready), 32'd0);
            bus.dmem_rvalid = (i == 2);
            bus.dmem_rdata  = 32'hCAFE_0042;
            cycle();
        end
        bus.dmem_rvalid = 1'b0;
        check("late_load_waddr", 32'(bus.waddr), 32'd4);
        check("late_load_wdata", bus.wdata,      32'hCAFE_0042);
        check("queued_ready",    32'(bus.in_ready), 32'd1);
        cycle();
        bus.in_valid = 1'b0;
        check("queued_alu_waddr", 32'(bus.waddr), 32'd6);
        check("queued_alu_wdata", bus.wdata,      32'h0000_1111);

        // rd=0 and in_reg_wr=0 never write
        issue(2'b00, 3'b000, 5'd0, 1'b1, 32'h1234_5678);
        cycle();
        bus.in_valid = 1'b0;
        check("rd0_alu_nowr", 32'(bus.reg_wr), 32'd0);
        issue(2'b01, 3'b010, 5'd0, 1'b1, 32'h0);
        cycle();
        bus.in_valid    = 1'b0;
        bus.dmem_rvalid = 1'b1;
        cycle();
        bus.dmem_rvalid = 1'b0;
        check("rd0_load_nowr", 32'(bus.reg_wr), 32'd0);
        issue(2'b10, 3'b000, 5'd7, 1'b0, 32'h0);
        cycle();
        bus.in_valid = 1'b0;
        check("nowr_rd7", 32'(bus.reg_wr),   32'd0);
        check("nowr_rdy", 32'(bus.in_ready), 32'd1);

        // Timeout: no response at all
        issue(2'b01, 3'b010, 5'd8, 1'b1, 32'h0);
        cycle();
        bus.in_valid = 1'b0;
        for (int i = 0; i < TO; i++) begin
            check("to_stall", 32'(bus.stall), 32'd1);
            cycle();
        end
        check("to_err",   32'(bus.load_err), 32'd1);
        check("to_nowr",  32'(bus.reg_wr),   32'd0);
        check("to_ready", 32'(bus.in_ready), 32'd1);
        cycle();
        check("to_err_pulse", 32'(bus.load_err), 32'd0);

        // Response in the last allowed cycle wins over the timeout
        issue(2'b01, 3'b010, 5'd8, 1'b1, 32'h0);
        cycle();
        bus.in_valid = 1'b0;
        for (int i = 0; i < TO; i++) begin
            bus.dmem_rvalid = (i == TO - 1);
            bus.dmem_rdata  = 32'h0BAD_F00D;
            cycle();
        end
        bus.dmem_rvalid = 1'b0;
        check("edge_wr",    32'(bus.reg_wr),   32'd1);
        check("edge_wdata", bus.wdata,         32'h0BAD_F00D);
        check("edge_noerr", 32'(bus.load_err), 32'd0);

        // Reset while waiting discards the load
        issue(2'b01, 3'b010, 5'd10, 1'b1, 32'h0);
        cycle();
        bus.in_valid = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
        #1;
        check("rst_mid_stall", 32'(bus.stall),    32'd0);
        check("rst_mid_ready", 32'(bus.in_ready), 32'd0);
        cycle();
        check("rst_mid_waddr", 32'(bus.waddr), 32'd0);
        reset = 1'b0;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h5555_AAAA;
        cycle();
        bus.dmem_rvalid = 1'b0;
        check("rst_late_nowr",  32'(bus.reg_wr),   32'd0);
        check("rst_late_noerr", 32'(bus.load_err), 32'd0);
        check("rst_late_ready", 32'(bus.in_ready), 32'd1);

        // Randomized traffic, checked every cycle by the compare process
        for (int i = 0; i < 3000; i++) begin
            reset             = ($urandom_range(0, 299) == 0);
            bus.in_valid      = ($urandom_range(0, 2) != 0);
            bus.in_wb_sel     = 2'($urandom_range(0, 3));
            bus.in_funct3     = 3'($urandom_range(0, 7));
            bus.in_rd         = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            bus.in_reg_wr     = ($urandom_range(0, 5) != 0);
            bus.in_alu_result = $urandom;
            bus.in_pc4        = $urandom;
            bus.in_imm        = $urandom;
            bus.dmem_rvalid   = ($urandom_range(0, 5) == 0);
            bus.dmem_rdata    = $urandom;
            cycle();
        end

        quiet();
        reset = 1'b0;
        cycle();
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
